// File: rtl/sound_pkg.sv
// Shared types and elaboration-time helpers for the
// multi-voice sound oscillator.
package sound_pkg;

  typedef enum logic [1:0] {
    SQUARE,
    SAW,
    TRIANGLE,
    PULSE25
  } wave_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RUN
  } voice_state_t;

  function automatic int calc_k(input int clk_hz,
                                input int steps);
    return clk_hz / steps;
  endfunction

  function automatic int calc_qw(input int k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring divider: constant dividend K over a runtime divisor,
// one quotient bit per cycle, tag carried alongside the job.
module serial_divider #(
  parameter int K      = 39062,
  parameter int Q_W    = 16,
  parameter int FREQ_W = 9,
  parameter int TAG_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FREQ_W-1:0] divisor,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              busy,
  output logic              done,
  output logic [Q_W-1:0]    quotient,
  output logic [TAG_W-1:0]  tag_out
);
  localparam int IW = $clog2(Q_W + 1);

  logic              busy_q, busy_d;
  logic [IW-1:0]     it_q, it_d;
  logic [FREQ_W-1:0] rem_q, rem_d;
  logic [FREQ_W-1:0] den_q, den_d;
  logic [Q_W-1:0]    quo_q, quo_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [FREQ_W:0]   rem_sh, rem_n;
  logic [Q_W-1:0]    quo_n;
  logic              ge, last;

  assign last = (it_q == IW'(Q_W - 1));

  always_comb begin
    busy_d = busy_q;
    it_d   = it_q;
    rem_d  = rem_q;
    den_d  = den_q;
    quo_d  = quo_q;
    tag_d  = tag_q;
    rem_sh = {rem_q, quo_q[Q_W-1]};
    ge     = (rem_sh >= {1'b0, den_q});
    rem_n  = ge ? (rem_sh - {1'b0, den_q}) : rem_sh;
    quo_n  = {quo_q[Q_W-2:0], ge};
    if (busy_q) begin
      rem_d = rem_n[FREQ_W-1:0];
      quo_d = quo_n;
      it_d  = it_q + 1'b1;
      if (last) busy_d = 1'b0;
    end else if (start) begin
      busy_d = 1'b1;
      it_d   = '0;
      rem_d  = '0;
      quo_d  = Q_W'(K);
      den_d  = divisor;
      tag_d  = tag_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      it_q   <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
      tag_q  <= '0;
    end else begin
      busy_q <= busy_d;
      it_q   <= it_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      quo_q  <= quo_d;
      tag_q  <= tag_d;
    end
  end

  // result is consumed on the edge that completes the last iteration
  assign busy     = busy_q;
  assign done     = busy_q && last;
  assign quotient = quo_n;
  assign tag_out  = tag_q;

endmodule

// File: rtl/poly_oscillator.sv
// Multi-voice tone generator: per-voice period counters fed by a
// shared serial divider, summed into a registered mix sample.
module poly_oscillator
  import sound_pkg::*;
#(
  parameter int CLK_HZ     = 10_000_000,
  parameter int STEPS      = 256,
  parameter int FREQ_W     = 9,
  parameter int NUM_VOICES = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_VOICES-1:0]          playSound,
  input  logic [NUM_VOICES*FREQ_W-1:0]   freq,
  input  logic [NUM_VOICES*2-1:0]        mode,
  output logic [NUM_VOICES-1:0]          atMax,
  output logic [NUM_VOICES-1:0]          active,
  output logic [$clog2(STEPS)+$clog2(NUM_VOICES)-1:0] mix
);
  localparam int SW  = $clog2(STEPS);
  localparam int MW  = SW + $clog2(NUM_VOICES);
  localparam int K   = calc_k(CLK_HZ, STEPS);
  localparam int Q_W = calc_qw(K);
  localparam int VW  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  function automatic logic [SW-1:0] wave(input wave_mode_t m,
                                         input logic [SW-1:0] s);
    logic [SW-1:0] ramp;
    ramp = {s[SW-2:0], 1'b0};
    case (m)
      SQUARE:   wave = {SW{s[SW-1]}};
      SAW:      wave = s;
      TRIANGLE: wave = s[SW-1] ? ~ramp : ramp;
      default:  wave = {SW{&s[SW-1:SW-2]}};
    endcase
  endfunction

  logic [FREQ_W-1:0]     f_v [NUM_VOICES];
  logic [SW-1:0]         smp [NUM_VOICES];
  logic [NUM_VOICES-1:0] elig;
  logic                  grant_vld;
  logic [VW-1:0]         grant_idx;
  logic                  div_start, div_busy, div_done;
  logic [FREQ_W-1:0]     div_den;
  logic [Q_W-1:0]        div_q;
  logic [VW-1:0]         div_tag;
  logic [MW-1:0]         mix_q, mix_d;

  // lowest-index eligible voice wins the divider
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (elig[v]) begin
        grant_vld = 1'b1;
        grant_idx = VW'(v);
      end
    end
    div_start = grant_vld && !div_busy;
    div_den   = f_v[grant_idx];
  end

  serial_divider #(
    .K      (K),
    .Q_W    (Q_W),
    .FREQ_W (FREQ_W),
    .TAG_W  (VW)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .divisor  (div_den),
    .tag_in   (grant_idx),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q),
    .tag_out  (div_tag)
  );

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    voice_state_t      state_q, state_d;
    logic [Q_W-1:0]    cnt_q, cnt_d, per_q, per_d;
    logic [SW-1:0]     step_q, step_d;
    logic [FREQ_W-1:0] jfreq_q, jfreq_d;
    logic              pend_q, pend_d, jok_q, jok_d;
    logic              at_q, at_d, act_q, act_d;
    logic              go, granted, landed;

    assign f_v[v]   = freq[v*FREQ_W +: FREQ_W];
    assign go       = playSound[v] && (f_v[v] != '0);
    assign elig[v]  = pend_q && go;
    assign granted  = div_start && (grant_idx == VW'(v));
    // jok drops when the voice idles, so a stale job is ignored
    assign landed   = div_done && (div_tag == VW'(v)) && jok_q;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      per_d   = per_q;
      step_d  = step_q;
      jfreq_d = jfreq_q;
      pend_d  = pend_q;
      jok_d   = jok_q;
      at_d    = 1'b0;
      if (!go) begin
        state_d = IDLE;
        cnt_d   = '0;
        step_d  = '0;
        pend_d  = 1'b0;
        jok_d   = 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_d = WAIT;
            pend_d  = 1'b1;
          end
          WAIT: begin
            if (landed) begin
              state_d = RUN;
              per_d   = div_q;
              cnt_d   = '0;
              jok_d   = 1'b0;
            end
          end
          RUN: begin
            if (landed) begin
              per_d = div_q;
              cnt_d = '0;
              jok_d = 1'b0;
            end else if (cnt_q == per_q - 1'b1) begin
              cnt_d  = '0;
              step_d = step_q + 1'b1;
              at_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
        if (granted) begin
          pend_d  = 1'b0;
          jok_d   = 1'b1;
          jfreq_d = f_v[v];
        end else if (state_q != IDLE && f_v[v] != jfreq_q) begin
          pend_d = 1'b1;
        end
      end
      act_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        per_q   <= '0;
        step_q  <= '0;
        jfreq_q <= '0;
        pend_q  <= 1'b0;
        jok_q   <= 1'b0;
        at_q    <= 1'b0;
        act_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        per_q   <= per_d;
        step_q  <= step_d;
        jfreq_q <= jfreq_d;
        pend_q  <= pend_d;
        jok_q   <= jok_d;
        at_q    <= at_d;
        act_q   <= act_d;
      end
    end

    assign smp[v]    = (state_q == RUN) ?
                       wave(wave_mode_t'(mode[v*2 +: 2]), step_q) : '0;
    assign atMax[v]  = at_q;
    assign active[v] = act_q;
  end

  always_comb begin
    mix_d = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      mix_d = mix_d + MW'(smp[v]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mix_q <= '0;
    else     mix_q <= mix_d;
  end

  assign mix = mix_q;

endmodule

// File: tb/tb_poly_oscillator.sv
// Bench for poly_oscillator: per-cycle comparison of active, atMax
// and mix against an arithmetic timeline model of each voice.
module tb_poly_oscillator;
  localparam int NV  = 4;
  localparam int FW  = 9;
  localparam int MW  = 10;
  localparam int K   = 10_000_000 / 256;
  localparam int QW  = $clog2(K + 1);
  localparam int LAT = QW + 1;
  localparam longint NEVER = 64'sd1 << 60;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NV-1:0]   play_sound = '0;
  logic [NV*FW-1:0] freq = '0;
  logic [NV*2-1:0] mode = '0;
  logic [NV-1:0]   at_max;
  logic [NV-1:0]   active;
  logic [MW-1:0]   mix;

  int     n_chk = 0;
  int     n_fail = 0;
  longint cyc = 0;
  bit     mon_en = 1'b0;
  int     max_mix = 0;

  bit     on [NV];
  longint rs [NV], toff [NV], anc [NV], anc0 [NV];
  int     per [NV], per0 [NV], base [NV], base0 [NV];
  int     md [NV], fq [NV];

  poly_oscillator dut (
    .clk       (clk),
    .rst       (rst),
    .playSound (play_sound),
    .freq      (freq),
    .mode      (mode),
    .atMax     (at_max),
    .active    (active),
    .mix       (mix)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs,
                       input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, want %0d",
               tag, cyc, obs, exp);
    end
  endtask

  function automatic int wave(input int m, input longint st);
    int x;
    x = int'(st % 256);
    case (m)
      0:       return (x >= 128) ? 255 : 0;
      1:       return x;
      2:       return (x < 128) ? 2 * x : 511 - 2 * x;
      default: return (x >= 192) ? 255 : 0;
    endcase
  endfunction

  function automatic bit run_at(input int v, input longint t);
    return on[v] && t >= rs[v] && t < toff[v];
  endfunction

  function automatic longint step_at(input int v, input longint t);
    if (t >= anc[v]) return base[v] + (t - anc[v]) / per[v];
    return base0[v] + (t - anc0[v]) / per0[v];
  endfunction

  function automatic bit strobe_at(input int v, input longint t);
    if (!run_at(v, t)) return 1'b0;
    if (t >= anc[v])
      return t > anc[v] && (t - anc[v]) % per[v] == 0;
    return t > anc0[v] && (t - anc0[v]) % per0[v] == 0;
  endfunction

  always @(negedge clk) begin : mon
    logic [NV-1:0] ea, em;
    int emix;
    if (mon_en) begin
      ea = '0;
      em = '0;
      emix = 0;
      for (int v = 0; v < NV; v++) begin
        ea[v] = run_at(v, cyc);
        em[v] = strobe_at(v, cyc);
        if (run_at(v, cyc - 1))
          emix += wave(md[v], step_at(v, cyc - 1));
      end
      check("active", active, ea);
      check("atMax", at_max, em);
      check("mix", mix, emix);
      if (int'(mix) > max_mix) max_mix = int'(mix);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_bit(input int v, input bit use_act,
                          input int lim, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (((use_act ? active[v] : at_max[v]) == 1'b0)
               && n < lim);
  endtask

  task automatic start_voices(input logic [NV-1:0] msk);
    int r;
    r = 0;
    for (int v = 0; v < NV; v++) begin
      if (msk[v]) begin
        freq[v*FW +: FW] = FW'(fq[v]);
        mode[v*2 +: 2]   = 2'(md[v]);
        play_sound[v]    = 1'b1;
        on[v] = (fq[v] != 0);
        if (fq[v] != 0) begin
          rs[v]    = cyc + 1 + (r + 1) * LAT;
          r++;
          per[v]   = K / fq[v];
          per0[v]  = per[v];
          anc[v]   = rs[v];
          anc0[v]  = rs[v];
          base[v]  = 0;
          base0[v] = 0;
          toff[v]  = NEVER;
        end
      end
    end
  endtask

  task automatic retune(input int v, input int f);
    longint l;
    int b;
    l = cyc + 1 + LAT;
    b = int'(step_at(v, l - 1));
    base0[v] = base[v];
    anc0[v]  = anc[v];
    per0[v]  = per[v];
    base[v]  = b;
    anc[v]   = l;
    per[v]   = K / f;
    freq[v*FW +: FW] = FW'(f);
  endtask

  task automatic stop_voice(input int v);
    play_sound[v] = 1'b0;
    if (toff[v] > cyc + 1) toff[v] = cyc + 1;
  endtask

  task automatic all_off();
    for (int v = 0; v < NV; v++) stop_voice(v);
    tick(25);
  endtask

  initial begin
    int n;
    longint t0;
    logic [NV-1:0] msk;
    int dv;
    for (int v = 0; v < NV; v++) begin
      on[v] = 1'b0;
      toff[v] = NEVER;
    end

    // power-on reset
    tick(3);
    check("por_active", active, 0);
    check("por_atmax", at_max, 0);
    check("por_mix", mix, 0);
    @(negedge clk) rst = 1'b0;
    tick(2);
    check("por_rel_active", active, 0);
    check("por_rel_mix", mix, 0);
    mon_en = 1'b1;

    // voice 0, 440 Hz square, then retune to 311 Hz
    fq[0] = 440;
    md[0] = 0;
    start_voices(4'b0001);
    wait_bit(0, 1'b1, 40, n);
    check("v0_act_lat", n, 18);
    wait_bit(0, 1'b0, 200, n);
    check("v0_first_per", n, 88);
    for (int i = 0; i < 2; i++) begin
      wait_bit(0, 1'b0, 200, n);
      check("v0_per", n, 88);
    end
    tick(127 * 88);
    while (((cyc + 1 + LAT) - anc[0]) % per[0] == 0) tick(1);
    retune(0, 311);
    tick(LAT + 1);
    check("retune_land", cyc, anc[0]);
    wait_bit(0, 1'b0, 300, n);
    check("retune_per1", n, 125);
    wait_bit(0, 1'b0, 300, n);
    check("retune_per2", n, 125);
    all_off();

    // three voices started together
    fq[0] = 440; fq[1] = 311; fq[2] = 262;
    md[0] = 0;   md[1] = 1;   md[2] = 2;
    t0 = cyc;
    start_voices(4'b0111);
    wait_bit(0, 1'b1, 80, n);
    check("v0_lat3", cyc - t0, 18);
    wait_bit(1, 1'b1, 80, n);
    check("v1_lat3", cyc - t0, 35);
    wait_bit(2, 1'b1, 80, n);
    check("v2_lat3", cyc - t0, 52);
    tick(700);
    all_off();

    // asynchronous reset in the middle of playback
    fq[0] = 440; fq[1] = 311;
    md[0] = 1;   md[1] = 1;
    start_voices(4'b0011);
    tick(600);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_active", active, 0);
    check("rst_atmax", at_max, 0);
    check("rst_mix", mix, 0);
    play_sound = '0;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      check("rst_hold_active", active, 0);
      check("rst_hold_mix", mix, 0);
    end
    @(negedge clk) rst = 1'b0;
    tick(1);
    check("rst_rel_active", active, 0);
    check("rst_rel_mix", mix, 0);
    for (int v = 0; v < NV; v++) on[v] = 1'b0;
    mon_en = 1'b1;
    tick(5);

    // drop during own divide, freq=0, drop mid-tone in saw
    fq[1] = 311;
    md[1] = 1;
    start_voices(4'b0010);
    tick(8);
    stop_voice(1);
    tick(20);
    check("drop_job_idle", active[1], 0);
    fq[0] = 440; fq[2] = 0;
    md[0] = 1;   md[2] = 1;
    start_voices(4'b0101);
    tick(400);
    stop_voice(0);
    tick(1);
    check("drop_active", active[0], 0);
    tick(1);
    check("drop_mix", mix, 0);
    check("f0_idle", active[2], 0);
    all_off();

    // randomized voice sets
    for (int i = 0; i < 3; i++) begin
      msk = 4'($urandom_range(1, 15));
      for (int v = 0; v < NV; v++) begin
        fq[v] = $urandom_range(262, 511);
        md[v] = $urandom_range(0, 3);
      end
      start_voices(msk);
      tick($urandom_range(100, 1500));
      do dv = $urandom_range(0, NV - 1); while (!msk[dv]);
      stop_voice(dv);
      tick(1500);
      all_off();
    end

    // four saw voices at 262 Hz run to the full-scale sum
    for (int v = 0; v < NV; v++) begin
      fq[v] = 262;
      md[v] = 1;
    end
    max_mix = 0;
    start_voices(4'b1111);
    tick(256 * 149 + 120);
    check("mix_peak", max_mix, 1020);
    all_off();

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/poly_oscillator.md
# poly_oscillator

Multi-voice, parametrised successor to the single-channel sound oscillator. It drives NUM_VOICES independent tone voices from one clock. Each voice has its own frequency, enable and waveform mode. A shared iterative divider turns each voice's frequency into a step period. The block sits between the game-event sound sequencer and the PWM/DAC output stage, and it supplies a registered mixed sample.

## Interface
Parameters:
- CLK_HZ, 10_000_000, system clock frequency
- STEPS, 256, waveform steps per tone period (power of two; step width SW = log2(STEPS) = 8)
- FREQ_W, 9, tone frequency width in Hz
- NUM_VOICES, 4, number of voices

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- playSound  in  NUM_VOICES  per-voice enable
- freq  in  NUM_VOICES*FREQ_W  packed per-voice frequency in Hz; voice v is at [v*FREQ_W +: FREQ_W]
- mode  in  NUM_VOICES*2  per-voice waveform select (0 square, 1 saw, 2 triangle, 3 pulse-25%)
- atMax  out  NUM_VOICES  one-cycle strobe when a voice's period counter wraps
- active  out  NUM_VOICES  1 when the voice is in RUN
- mix  out  SW+log2(NUM_VOICES)  registered sum of the voice samples

## Operation
- K = CLK_HZ/STEPS, computed at elaboration and truncated (39062 with the defaults). Quotient width Q_W = clog2(K+1) (16).
- Per-voice period: P = floor(K/freq). For 440 Hz P = 88, for 311 Hz P = 125, for 262 Hz P = 149.
- Per-voice FSM:
  - IDLE: cnt = 0, step = 0. Goes to WAIT when playSound=1 and freq≠0.
  - WAIT: a divide request is pending. Goes to RUN when the divider returns this voice's result.
  - RUN: cnt counts 0..P-1. When cnt == P-1: atMax=1, cnt←0, step←step+1 (wraps mod STEPS).
  - From any state, playSound=0 or freq=0 forces the voice to IDLE on the next edge.
- Frequency change in RUN (freq differs from the latched job freq):
  - Sets the voice's pending bit; the voice stays in RUN using the old P.
  - When the new P lands, cnt←0 and step is preserved.
- Divider arbiter:
  - Serves the lowest-index pending voice.
  - Samples that voice's freq at job start.
  - If that voice's freq differs from the sample when the job completes, the result is still written and the pending bit is set again.
- Sample per voice (s = step):
  - square: s[SW-1] ? max : 0
  - saw: s
  - triangle: s[SW-1] ? ~{s[SW-2:0],0} : {s[SW-2:0],0}
  - pulse-25%: s[SW-1:SW-2]==3 ? max : 0
  - A voice that is not in RUN contributes 0.
- mix is the unsigned sum of all voice samples. It is sized so it never overflows.

## Timing
- Reset values: atMax=0, active=0, mix=0. All FSMs are IDLE, all pending bits are 0, and the divider is idle.
- Divider latency is Q_W+1 cycles: 1 load cycle plus Q_W restoring iterations. The result is written at the end of the last iteration.
- Cycle numbering below counts edges after the edge that sees playSound=1, with the divider free:
  - edge 1: WAIT
  - edge 1+Q_W+1: RUN
  - RUN edge + P: first atMax
- Successive atMax strobes are exactly P cycles apart.
- A voice queued behind another job waits a further Q_W+1 cycles per job ahead of it.
- atMax and active are registered. mix is registered one cycle after the step update.
- step wraps STEPS-1 → 0 with no extra cycle.
- rst asserted mid-operation clears everything immediately. Any in-flight divide is discarded.
- playSound dropping during the voice's own divide job: the job completes, but its result is discarded and the voice stays IDLE.

## Structure
- Shared package `sound_pkg`:
  - `wave_mode_t` enum (SQUARE, SAW, TRIANGLE, PULSE25)
  - `voice_state_t` enum (IDLE, WAIT, RUN)
  - K and Q_W derivation functions
- Sub-module `serial_divider`:
  - Restoring divider; constant dividend K, FREQ_W-bit divisor.
  - Handshake: start/busy/done, plus a voice tag that passes through unchanged.
- Per-voice logic sits in a generate loop inside `poly_oscillator`.

## Test plan
- Reset: assert rst asynchronously mid-cycle → atMax=0, active=0 and mix=0 immediately; they hold through 2 clocks; no change on release.
- Voice 0 at 440 Hz, square: active after 18 cycles; atMax strobes every 88 cycles; mix toggles 0↔255 every 128 atMax strobes.
- Voices 0/1/2 at 440/311/262 Hz started on the same cycle:
  - active asserts at 18/35/52 cycles.
  - Periods are 88/125/149.
- Voice 0 changes 440→311 Hz in RUN: old 88-cycle period continues until the new P lands; then cnt resets, step is kept, and the period becomes 125.
- Voice 0 in saw mode: playSound=0 mid-tone → IDLE next edge, active=0, mix drops to 0 one cycle later. freq=0 with playSound=1 → voice never leaves IDLE.
- All 4 voices at 262 Hz, mode saw, steps aligned: after the last voice enters RUN, mix = 4×step, reaching the maximum 1020 without wrap.
